csi2_raw10_depacketizer: RTL and testbench

//  Receive-side counterpart of the pix2byte/csi_tx path: consumes the merged CSI-2 byte stream from the D-PHY RX,

---
 rtl/csi2_raw10_depacketizer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_csi2_raw10_depacketizer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_raw10_depacketizer.sv
// csi2_raw10_depacketizer: CSI-2 byte stream -> RAW10 fv/lv/pixel stream.
// Optional payload CRC-16 check enabled by defining CSI2_CRC_CHECK_EN.
module csi2_raw10_depacketizer #(
  parameter logic [1:0]  VC       = 2'd0,
  parameter logic [5:0]  DT_RAW10 = 6'h2B,
  parameter logic [15:0] MAX_WC   = 16'd4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       pkt_start_i,
  output logic       fv_o,
  output logic       lv_o,
  output logic       pixel_en_o,
  output logic [9:0] pixel_data_o,
  output logic       err_dt_o,
  output logic       err_wc_o,
  output logic       err_sync_o,
  output logic       err_crc_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SKIP, S_PAY, S_CRC
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      hdr_cnt_q;
  logic [7:0]      di_q, wcl_q, wch_q;
  logic [16:0]     cnt_q;
  logic [2:0]      grp_idx_q;
  logic [3:0][7:0] b_q;
  logic [2:0][9:0] sh_q;
  logic [1:0]      pend_q;
  logic            line_end_q, fe_pend_q;

  logic        take, abort, hdr_last;
  logic        pay_take, crc_take;
  logic [15:0] wc;
  logic [5:0]  dt;
  logic        long_pkt, wc_bad;
  logic        go_pay, go_crc, go_skip;
  logic        ev_fs, ev_fe, ev_dt, ev_wc, ev_ls;

  assign take     = byte_valid_i & ~pkt_start_i;
  assign abort    = byte_valid_i & pkt_start_i
                  & (state_q != S_IDLE);
  assign hdr_last = take & (state_q == S_HDR)
                  & (hdr_cnt_q == 2'd3);
  assign pay_take = take & (state_q == S_PAY);
  assign crc_take = take & (state_q == S_CRC);
  assign wc       = {wch_q, wcl_q};
  assign dt       = di_q[5:0];
  assign long_pkt = dt >= 6'h10;
  assign wc_bad   = (wc % 16'd5 != 16'd0)
                  || (wc > MAX_WC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_HDR;
    end else if (byte_valid_i) begin
      unique case (state_q)
        S_IDLE: if (pkt_start_i) state_d = S_HDR;
        S_HDR: begin
          if (hdr_cnt_q == 2'd3) begin
            if (go_pay)       state_d = S_PAY;
            else if (go_crc)  state_d = S_CRC;
            else if (go_skip) state_d = S_SKIP;
            else              state_d = S_IDLE;
          end
        end
        S_SKIP: if (cnt_q == 17'd1) state_d = S_IDLE;
        S_PAY:  if (cnt_q == 17'd1) state_d = S_CRC;
        S_CRC:  if (cnt_q == 17'd1) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Header decode: what the completed header asks for.
  always_comb begin
    go_pay  = 1'b0;
    go_crc  = 1'b0;
    go_skip = 1'b0;
    ev_fs   = 1'b0;
    ev_fe   = 1'b0;
    ev_dt   = 1'b0;
    ev_wc   = 1'b0;
    ev_ls   = 1'b0;
    if (hdr_last) begin
      if (di_q[7:6] != VC) begin
        go_skip = long_pkt;
      end else if (dt == 6'h00) begin
        ev_fs = 1'b1;
      end else if (dt == 6'h01) begin
        ev_fe = 1'b1;
      end else if (long_pkt) begin
        if (dt != DT_RAW10) begin
          ev_dt   = 1'b1;
          go_skip = 1'b1;
        end else if (wc_bad) begin
          ev_wc   = 1'b1;
          go_skip = 1'b1;
        end else if (!fv_o) begin
          ev_ls   = 1'b1;
          go_skip = 1'b1;
        end else if (wc == 16'd0) begin
          go_crc = 1'b1;
        end else begin
          go_pay = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fv_o         <= 1'b0;
      lv_o         <= 1'b0;
      pixel_en_o   <= 1'b0;
      pixel_data_o <= '0;
      err_dt_o     <= 1'b0;
      err_wc_o     <= 1'b0;
      err_sync_o   <= 1'b0;
      hdr_cnt_q    <= '0;
      di_q         <= '0;
      wcl_q        <= '0;
      wch_q        <= '0;
      cnt_q        <= '0;
      grp_idx_q    <= '0;
      b_q          <= '0;
      sh_q         <= '0;
      pend_q       <= '0;
      line_end_q   <= 1'b0;
      fe_pend_q    <= 1'b0;
    end else begin
      err_dt_o   <= ev_dt;
      err_wc_o   <= ev_wc;
      err_sync_o <= abort | ev_ls
                  | (ev_fs & fv_o & ~fe_pend_q)
                  | (ev_fe & ~fv_o);

      if (pend_q != 2'd0) begin
        pixel_en_o   <= 1'b1;
        pixel_data_o <= sh_q[0];
        sh_q         <= {10'd0, sh_q[2:1]};
        pend_q       <= pend_q - 2'd1;
      end else begin
        pixel_en_o <= 1'b0;
        if (pixel_en_o && line_end_q) begin
          lv_o       <= 1'b0;
          line_end_q <= 1'b0;
        end
      end

      // FE seen while a line still drains: hold fv until lv drops.
      if (fe_pend_q && !lv_o) begin
        fv_o      <= 1'b0;
        fe_pend_q <= 1'b0;
      end

      if (byte_valid_i && pkt_start_i) begin
        di_q      <= byte_i;
        hdr_cnt_q <= 2'd1;
        if (abort) begin
          pend_q     <= '0;
          pixel_en_o <= 1'b0;
          lv_o       <= 1'b0;
          line_end_q <= 1'b0;
          grp_idx_q  <= '0;
        end
      end

      if (take && state_q == S_HDR) begin
        hdr_cnt_q <= hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'd1) wcl_q <= byte_i;
        if (hdr_cnt_q == 2'd2) wch_q <= byte_i;
      end

      if (ev_fs) begin
        fv_o      <= 1'b1;
        fe_pend_q <= 1'b0;
      end
      if (ev_fe && fv_o) begin
        if (lv_o || line_end_q || pend_q != 2'd0)
          fe_pend_q <= 1'b1;
        else
          fv_o <= 1'b0;
      end

      if (go_skip) cnt_q <= {1'b0, wc} + 17'd2;
      if (go_crc)  cnt_q <= 17'd2;
      if (go_pay) begin
        cnt_q     <= {1'b0, wc};
        grp_idx_q <= '0;
      end

      if (pay_take) begin
        cnt_q <= (cnt_q == 17'd1) ? 17'd2
               : cnt_q - 17'd1;
        if (grp_idx_q == 3'd4) begin
          grp_idx_q    <= '0;
          pixel_en_o   <= 1'b1;
          pixel_data_o <= {b_q[0], byte_i[1:0]};
          sh_q <= {{b_q[3], byte_i[7:6]},
                   {b_q[2], byte_i[5:4]},
                   {b_q[1], byte_i[3:2]}};
          pend_q     <= 2'd3;
          lv_o       <= 1'b1;
          line_end_q <= (cnt_q == 17'd1);
        end else begin
          b_q[grp_idx_q[1:0]] <= byte_i;
          grp_idx_q <= grp_idx_q + 3'd1;
        end
      end

      if (take && (state_q == S_SKIP
                || state_q == S_CRC))
        cnt_q <= cnt_q - 17'd1;
    end
  end

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc_q;
  logic [7:0]  crc_lo_q;

  // Reflected CCITT polynomial, data consumed LSB first.
  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q     <= 16'hFFFF;
      crc_lo_q  <= '0;
      err_crc_o <= 1'b0;
    end else begin
      err_crc_o <= 1'b0;
      if (go_pay || go_crc)
        crc_q <= 16'hFFFF;
      else if (pay_take)
        crc_q <= crc_upd(crc_q, byte_i);
      if (crc_take) begin
        if (cnt_q == 17'd2)
          crc_lo_q <= byte_i;
        else
          err_crc_o <= {byte_i, crc_lo_q} != crc_q;
      end
    end
  end
`else
  assign err_crc_o = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_raw10_depacketizer.sv
// tb_csi2_raw10_depacketizer: directed vectors for the RAW10 depacketizer.
// Covers frame/line framing, unpacking, error pulses and aborts.
module tb_csi2_raw10_depacketizer;

  localparam logic [7:0] DI_FS  = 8'h00;
  localparam logic [7:0] DI_FE  = 8'h01;
  localparam logic [7:0] DI_RAW = 8'h2B;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_i = '0;
  logic       byte_valid_i = 1'b0;
  logic       pkt_start_i = 1'b0;
  logic       fv_o, lv_o, pixel_en_o;
  logic [9:0] pixel_data_o;
  logic       err_dt_o, err_wc_o;
  logic       err_sync_o, err_crc_o;

  always #5 clk = ~clk;

  csi2_raw10_depacketizer dut (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .pkt_start_i  (pkt_start_i),
    .fv_o         (fv_o),
    .lv_o         (lv_o),
    .pixel_en_o   (pixel_en_o),
    .pixel_data_o (pixel_data_o),
    .err_dt_o     (err_dt_o),
    .err_wc_o     (err_wc_o),
    .err_sync_o   (err_sync_o),
    .err_crc_o    (err_crc_o)
  );

  int n_chk = 0;
  int n_bad = 0;

  int npix = 0, pix_out = 0, lcnt = 0;
  int n_dt = 0, n_wc = 0, n_sync = 0, n_crc = 0;
  logic       lv_d = 1'b0;
  logic [9:0] pixq[$];
  int         lines[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (lv_o && !lv_d) lcnt = 0;
      if (pixel_en_o) begin
        npix++;
        lcnt++;
        pixq.push_back(pixel_data_o);
        if (!lv_o) pix_out++;
      end
      if (!lv_o && lv_d) lines.push_back(lcnt);
      lv_d = lv_o;
      n_dt   += int'(err_dt_o);
      n_wc   += int'(err_wc_o);
      n_sync += int'(err_sync_o);
      n_crc  += int'(err_crc_o);
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input logic s);
    byte_i       = b;
    pkt_start_i  = s;
    byte_valid_i = 1'b1;
    tick(1);
    byte_valid_i = 1'b0;
    pkt_start_i  = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] di, input logic [15:0] wc);
    put(di, 1'b1);
    put(wc[7:0], 1'b0);
    put(wc[15:8], 1'b0);
    put(8'h00, 1'b0);
  endtask

  task automatic skip_bytes(input int n);
    for (int i = 0; i < n; i++) put(i[7:0], 1'b0);
  endtask

  task automatic group5();
    put(8'hFF, 1'b0);
    put(8'h00, 1'b0);
    put(8'hAA, 1'b0);
    put(8'h55, 1'b0);
    put(8'hE4, 1'b0);
  endtask

  task automatic line5();
    hdr(DI_RAW, 16'd5);
    group5();
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    tick(5);
  endtask

  function automatic logic [15:0] crc_b(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  initial begin
    int         s_pix, s_err, s_wc, s_sync, s_dt, s_crc;
    int         k, mism, badl, n;
    logic [9:0] exp_q[$];
    logic [9:0] p[4];
    logic [7:0] gb[5];
    logic [15:0] c;

    tick(3);
    chk("rst_out", {fv_o, lv_o, pixel_en_o, pixel_data_o,
                    err_dt_o, err_wc_o, err_sync_o, err_crc_o}, 0);
    reset = 1'b0;
    tick(2);

    hdr(DI_FS, 16'd0);
    chk("fs_fv", fv_o, 1);

    hdr(DI_RAW, 16'd5);
    put(8'hFF, 1'b0);
    put(8'h00, 1'b0);
    put(8'hAA, 1'b0);
    put(8'h55, 1'b0);
    put(8'hE4, 1'b0);
    chk("g_p0", {lv_o, pixel_en_o, pixel_data_o}, {2'b11, 10'h3FC});
    put(8'h00, 1'b0);
    chk("g_p1", {pixel_en_o, pixel_data_o}, {1'b1, 10'h001});
    put(8'h00, 1'b0);
    chk("g_p2", {pixel_en_o, pixel_data_o}, {1'b1, 10'h2AA});
    tick(1);
    chk("g_p3", {lv_o, pixel_en_o, pixel_data_o}, {2'b11, 10'h157});
    tick(1);
    chk("g_end", {lv_o, pixel_en_o}, 0);
    tick(3);

    pixq.delete();
    lines.delete();
    s_err = n_dt + n_wc + n_sync;
    k = 0;
    for (int l = 0; l < 8; l++) begin
      hdr(DI_RAW, 16'd320);
      for (int g = 0; g < 64; g++) begin
        for (int j = 0; j < 4; j++) begin
          p[j] = 10'(l * 37 + (4 * g + j) * 5);
          exp_q.push_back(p[j]);
        end
        gb[0] = p[0][9:2];
        gb[1] = p[1][9:2];
        gb[2] = p[2][9:2];
        gb[3] = p[3][9:2];
        gb[4] = {p[3][1:0], p[2][1:0], p[1][1:0], p[0][1:0]};
        for (int j = 0; j < 5; j++) begin
          put(gb[j], 1'b0);
          if (k % 7 == 6) tick(1);
          k++;
        end
      end
      put(8'h00, 1'b0);
      put(8'h00, 1'b0);
      tick(3);
    end
    hdr(DI_FE, 16'd0);
    chk("fe_fv", fv_o, 0);
    chk("ln_num", lines.size(), 8);
    badl = 0;
    foreach (lines[i]) if (lines[i] != 256) badl++;
    chk("ln_len", badl, 0);
    chk("img_n", pixq.size(), 2048);
    mism = 0;
    for (int i = 0; i < pixq.size() && i < exp_q.size(); i++)
      if (pixq[i] !== exp_q[i]) mism++;
    chk("img_val", mism, 0);
    chk("img_err", n_dt + n_wc + n_sync - s_err, 0);

    hdr(DI_FS, 16'd0);
    s_pix = npix;
    s_wc  = n_wc;
    hdr(DI_RAW, 16'd321);
    chk("wc_pulse", err_wc_o, 1);
    skip_bytes(323);
    tick(2);
    chk("wc_cnt", n_wc - s_wc, 1);
    chk("wc_pix", npix - s_pix, 0);
    line5();
    chk("wc_next", npix - s_pix, 4);

    s_pix  = npix;
    s_sync = n_sync;
    hdr(DI_RAW, 16'd320);
    skip_bytes(100);
    put(DI_RAW, 1'b1);
    chk("ab_sync", err_sync_o, 1);
    chk("ab_lv", lv_o, 0);
    put(8'd5, 1'b0);
    put(8'd0, 1'b0);
    put(8'd0, 1'b0);
    group5();
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    tick(5);
    chk("ab_pix", npix - s_pix, 81);
    n = pixq.size();
    chk("ab_p01", {pixq[n-4], pixq[n-3]}, {10'h3FC, 10'h001});
    chk("ab_p23", {pixq[n-2], pixq[n-1]}, {10'h2AA, 10'h157});
    chk("ab_nsync", n_sync - s_sync, 1);

    s_pix = npix;
    s_err = n_dt + n_wc + n_sync;
    hdr({2'd1, 6'h2B}, 16'd320);
    skip_bytes(322);
    tick(2);
    chk("vc_pix", npix - s_pix, 0);
    chk("vc_err", n_dt + n_wc + n_sync - s_err, 0);
    chk("vc_fv", fv_o, 1);
    hdr(DI_FE, 16'd0);
    chk("fe_ok", fv_o, 0);
    s_err = n_dt + n_wc + n_sync;
    hdr(DI_FE, 16'd0);
    chk("fe2_sync", err_sync_o, 1);
    tick(2);
    chk("fe2_err", n_dt + n_wc + n_sync - s_err, 1);
    chk("fe2_fv", fv_o, 0);

    hdr(DI_FS, 16'd0);
    s_dt  = n_dt;
    s_pix = npix;
    hdr(8'h12, 16'd5);
    chk("dt_pulse", err_dt_o, 1);
    skip_bytes(7);
    tick(2);
    chk("dt_cnt", n_dt - s_dt, 1);
    s_err = n_dt + n_wc + n_sync;
    hdr(DI_RAW, 16'd0);
    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    line5();
    chk("wc0", npix - s_pix, 4);
    s_pix = npix;
    hdr(DI_RAW, 16'd4005);
    chk("wc_max1", err_wc_o, 1);
    skip_bytes(4007);
    hdr(DI_RAW, 16'd4000);
    skip_bytes(4002);
    tick(5);
    chk("wc_max_pix", npix - s_pix, 3200);
    chk("wc_max_err", n_dt + n_wc + n_sync - s_err, 1);
    hdr(DI_FE, 16'd0);

    s_pix  = npix;
    s_sync = n_sync;
    hdr(DI_RAW, 16'd5);
    chk("oof_sync", err_sync_o, 1);
    skip_bytes(7);
    tick(2);
    chk("oof_pix", npix - s_pix, 0);
    chk("oof_nsync", n_sync - s_sync, 1);

    hdr(DI_FS, 16'd0);
    s_pix = npix;
    hdr(DI_RAW, 16'd5);
    put(8'hFF, 1'b0);
    put(8'h00, 1'b0);
    put(8'hAA, 1'b0);
    put(8'h55, 1'b0);
    reset = 1'b1;
    tick(2);
    chk("rst2", {fv_o, lv_o, pixel_en_o}, 0);
    reset = 1'b0;
    put(8'hE4, 1'b0);
    tick(5);
    chk("rst2_pix", npix - s_pix, 0);

`ifdef CSI2_CRC_CHECK_EN
    hdr(DI_FS, 16'd0);
    s_crc = n_crc;
    c = 16'hFFFF;
    for (int i = 0; i < 5; i++) c = crc_b(c, 8'(i));
    hdr(DI_RAW, 16'd5);
    for (int i = 0; i < 5; i++) put(8'(i), 1'b0);
    put(c[7:0] ^ 8'h01, 1'b0);
    put(c[15:8], 1'b0);
    tick(2);
    chk("crc_bad", n_crc - s_crc, 1);
    hdr(DI_RAW, 16'd5);
    for (int i = 0; i < 5; i++) put(8'(i), 1'b0);
    put(c[7:0], 1'b0);
    put(c[15:8], 1'b0);
    tick(2);
    chk("crc_ok", n_crc - s_crc, 1);
    hdr(DI_FE, 16'd0);
`else
    s_crc = 0;
    c = crc_b(16'hFFFF, 8'h00);
    chk("crc_off", n_crc - s_crc, 0);
`endif

    chk("pix_in_lv", pix_out, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
